// File: rtl/ahb_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_rr_arbiter_if
// Description : Request/lock/grant bundle between AHB managers and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_rr_arbiter_if #(
    parameter int MANAGERS = 4
);
    localparam int c_ID_W = $clog2(MANAGERS);

    logic [MANAGERS-1:0] requestV;
    logic [MANAGERS-1:0] lockV;
    logic                HREADY;
    logic [MANAGERS-1:0] grantedV;
    logic [c_ID_W-1:0]   grantedID;
    logic                grant_valid;
    logic                HMASTLOCK;

    modport master (
        output requestV, lockV, HREADY,
        input  grantedV, grantedID, grant_valid, HMASTLOCK
    );

    modport slave (
        input  requestV, lockV, HREADY,
        output grantedV, grantedID, grant_valid, HMASTLOCK
    );
endinterface
`default_nettype wire

// File: rtl/ahb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_rr_arbiter
// Description : Round-robin / fixed-priority AHB bus arbiter with lock and
//               optional hold cap; grant state only moves on HREADY beats.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_rr_arbiter #(
    parameter int MANAGERS        = 4,
    parameter int DEFAULT_MANAGER = 0,
    parameter int MAX_HOLD        = 16,
    parameter int FIXED_PRIO      = 0
) (
    input  wire logic       HCLK,
    input  wire logic       HRESET,
    ahb_rr_arbiter_if.slave bus
);

    localparam int c_ID_W   = $clog2(MANAGERS);
    localparam int c_HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX       = (MAX_HOLD > 0) ? c_HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [c_ID_W-1:0]   c_DEFAULT_ID     = c_ID_W'(DEFAULT_MANAGER);
    localparam logic [c_ID_W-1:0]   c_LAST_ID_RST    = c_ID_W'(MANAGERS - 1);
    localparam logic [MANAGERS-1:0] c_ONE            = MANAGERS'(1);
    localparam logic [MANAGERS-1:0] c_DEFAULT_ONEHOT = c_ONE << DEFAULT_MANAGER;

    localparam logic [1:0] c_ST_PARK   = 2'd0;
    localparam logic [1:0] c_ST_OWNED  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic [1:0]          r_state;
    logic [c_ID_W-1:0]   r_owner;
    logic [MANAGERS-1:0] r_grant_v;
    logic                r_grant_valid;
    logic                r_mastlock;
    logic [c_ID_W-1:0]   r_last_id;
    logic [c_HOLD_W-1:0] r_hold_cnt;

    logic                w_own_req;
    logic                w_own_lock;
    logic                w_others;
    logic                w_hold_cap;
    logic                w_ap;
    logic                w_win_found;
    logic [c_ID_W-1:0]   w_win_id;
    logic [c_ID_W-1:0]   w_scan_id;

    always_comb begin
        w_own_req  = bus.requestV[r_owner];
        w_own_lock = bus.lockV[r_owner];
        w_others   = |(bus.requestV & ~r_grant_v);
        w_hold_cap = (MAX_HOLD != 0) && (r_hold_cnt == c_HOLD_MAX) && w_others;
        w_ap       = 1'b0;
        case (r_state)
            c_ST_PARK:   w_ap = 1'b1;
            c_ST_OWNED:  w_ap = !w_own_req || w_hold_cap;
            c_ST_LOCKED: w_ap = !w_own_lock && !w_own_req;
            default:     w_ap = 1'b1;
        endcase
    end

    // Loops run backwards so the last hit is the first index in search order;
    // the rotating scan ends on last_id, so the owner only wins when alone.
    always_comb begin
        w_win_found = |bus.requestV;
        w_win_id    = '0;
        w_scan_id   = '0;
        if (FIXED_PRIO != 0) begin
            for (int k = MANAGERS - 1; k >= 0; k--) begin
                w_scan_id = c_ID_W'(k);
                if (bus.requestV[w_scan_id]) w_win_id = w_scan_id;
            end
        end else begin
            for (int k = MANAGERS; k >= 1; k--) begin
                w_scan_id = c_ID_W'((int'(r_last_id) + k) % MANAGERS);
                if (bus.requestV[w_scan_id]) w_win_id = w_scan_id;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state       <= c_ST_PARK;
            r_owner       <= c_DEFAULT_ID;
            r_grant_v     <= c_DEFAULT_ONEHOT;
            r_grant_valid <= 1'b0;
            r_mastlock    <= 1'b0;
            r_last_id     <= c_LAST_ID_RST;
            r_hold_cnt    <= '0;
        end else if (bus.HREADY) begin
            if (w_ap) begin
                r_hold_cnt <= '0;
                if (w_win_found) begin
                    r_owner       <= w_win_id;
                    r_grant_v     <= c_ONE << w_win_id;
                    r_grant_valid <= 1'b1;
                    r_last_id     <= w_win_id;
                    if (bus.lockV[w_win_id]) begin
                        r_state    <= c_ST_LOCKED;
                        r_mastlock <= 1'b1;
                    end else begin
                        r_state    <= c_ST_OWNED;
                        r_mastlock <= 1'b0;
                    end
                end else begin
                    r_state       <= c_ST_PARK;
                    r_owner       <= c_DEFAULT_ID;
                    r_grant_v     <= c_DEFAULT_ONEHOT;
                    r_grant_valid <= 1'b0;
                    r_mastlock    <= 1'b0;
                end
            end else if (r_state == c_ST_LOCKED) begin
                // Lock released but owner still requesting: keep the bus, restart the cap.
                if (!w_own_lock) begin
                    r_state    <= c_ST_OWNED;
                    r_mastlock <= 1'b0;
                    r_hold_cnt <= '0;
                end
            end else if ((r_state == c_ST_OWNED) && (r_hold_cnt != c_HOLD_MAX)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign bus.grantedV    = r_grant_v;
    assign bus.grantedID   = r_owner;
    assign bus.grant_valid = r_grant_valid;
    assign bus.HMASTLOCK   = r_mastlock;

endmodule
`default_nettype wire
